// File: rtl/hazard_forwarding_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_forwarding_unit_pkg
//
// Shared definitions for the hazard/forwarding control beside the ID stage:
//   - fwd_sel_e    : operand forwarding select encodings (MX1/MX2/MX3)
//   - hz_state_e   : load-use stall FSM state encodings
//   - REG_G0       : register specifier of %g0, which never forwards
// ----------------------------------------------------------------------------
package hazard_forwarding_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand comes from the register file read
    FWD_EX  = 2'b01,  // bypass from the EX stage result
    FWD_MEM = 2'b10,  // bypass from the MEM stage result
    FWD_WB  = 2'b11   // bypass from the WB stage result
  } fwd_sel_e;

  typedef enum logic {
    HZ_RUN   = 1'b0,  // normal flow, may detect a load-use hazard
    HZ_STALL = 1'b1   // the single bubble cycle; hazards ignored here
  } hz_state_e;

  localparam int REG_G0 = 0;

endpackage : hazard_forwarding_unit_pkg

// File: rtl/hazard_forwarding_unit_fwd_select.sv
// ----------------------------------------------------------------------------
// hazard_forwarding_unit_fwd_select
//
// Combinational priority comparator for one source operand. Picks the
// youngest in-flight producer of the source register: EX > MEM > WB, falling
// back to the register file. %g0 and unused sources always select the
// register file.
//
// Ports:
//   src       in  REG_W  source register specifier
//   src_used  in  1      the instruction actually reads this source
//   ex_rd     in  REG_W  EX destination
//   ex_en     in  1      EX writes the register file
//   mem_rd    in  REG_W  MEM destination
//   mem_en    in  1      MEM writes the register file
//   wb_rd     in  REG_W  WB destination
//   wb_en     in  1      WB writes the register file
//   sel       out FWD_W  forwarding select (see fwd_sel_e)
// ----------------------------------------------------------------------------
module hazard_forwarding_unit_fwd_select
  import hazard_forwarding_unit_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int FWD_W = 2
) (
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_en,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_en,
  output logic [FWD_W-1:0] sel
);

  logic     src_live;
  fwd_sel_e sel_enc;

  assign src_live = src_used && (src != REG_W'(REG_G0));

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_enc = FWD_RF;
    if (src_live) begin
      if (ex_en && (ex_rd == src)) begin
        sel_enc = FWD_EX;
      end else if (mem_en && (mem_rd == src)) begin
        sel_enc = FWD_MEM;
      end else if (wb_en && (wb_rd == src)) begin
        sel_enc = FWD_WB;
      end
    end
  end

  assign sel = FWD_W'(sel_enc);

endmodule : hazard_forwarding_unit_fwd_select

// File: rtl/hazard_forwarding_unit.sv
// ----------------------------------------------------------------------------
// hazard_forwarding_unit
//
// Control-side companion of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Generates operand forwarding selects for the instruction in ID, inserts
// exactly one bubble on a load-use hazard, and clears IF/ID to annul a delay
// slot. An annul that arrives while the pipe is stalled is held pending and
// issued on the cycle the stall releases.
//
// Optional build macro:
//   HAZARD_STATS_EN  adds free-running stall_count / annul_count outputs.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   ID_rs1, ID_rs2, ID_rd      source specifiers of the instruction in ID
//   ID_uses_rs2                0 for the immediate (i=1) form
//   ID_is_store                rd is read as store data
//   EX_RD, EX_RF_en, EX_load   EX destination, write enable, load flag
//   MEM_RD, MEM_RF_en          MEM destination and write enable
//   WB_RD, WB_RF_en            WB destination and write enable
//   annul_req                  one-cycle pulse: annul the delay slot in IF
//   fwd_a, fwd_b, fwd_c        forwarding selects for MX1, MX2, MX3
//   PC_LE, nPC_LE, IF_ID_LE    load enables, low while stalling
//   IF_ID_clr                  IF/ID clear (annul)
//   ID_EX_clr                  ID/EX clear (bubble)
//   stall                      load-use stall active this cycle
//   stall_count, annul_count   (HAZARD_STATS_EN only) event counters
// ----------------------------------------------------------------------------
module hazard_forwarding_unit
  import hazard_forwarding_unit_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int FWD_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic [REG_W-1:0] ID_rd,
  input  logic             ID_uses_rs2,
  input  logic             ID_is_store,
  input  logic [REG_W-1:0] EX_RD,
  input  logic             EX_RF_en,
  input  logic             EX_load,
  input  logic [REG_W-1:0] MEM_RD,
  input  logic             MEM_RF_en,
  input  logic [REG_W-1:0] WB_RD,
  input  logic             WB_RF_en,
  input  logic             annul_req,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic [FWD_W-1:0] fwd_c,
  output logic             PC_LE,
  output logic             nPC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_clr,
  output logic             ID_EX_clr,
`ifdef HAZARD_STATS_EN
  output logic [31:0]      stall_count,
  output logic [31:0]      annul_count,
`endif
  output logic             stall
);

  // --------------------------------------------------------------------------
  // Forwarding selects
  // --------------------------------------------------------------------------
  logic [FWD_W-1:0] sel_a;
  logic [FWD_W-1:0] sel_b;
  logic [FWD_W-1:0] sel_c;

  hazard_forwarding_unit_fwd_select #(.REG_W(REG_W), .FWD_W(FWD_W)) u_fwd_a (
    .src      (ID_rs1),
    .src_used (1'b1),
    .ex_rd    (EX_RD),
    .ex_en    (EX_RF_en),
    .mem_rd   (MEM_RD),
    .mem_en   (MEM_RF_en),
    .wb_rd    (WB_RD),
    .wb_en    (WB_RF_en),
    .sel      (sel_a)
  );

  hazard_forwarding_unit_fwd_select #(.REG_W(REG_W), .FWD_W(FWD_W)) u_fwd_b (
    .src      (ID_rs2),
    .src_used (ID_uses_rs2),
    .ex_rd    (EX_RD),
    .ex_en    (EX_RF_en),
    .mem_rd   (MEM_RD),
    .mem_en   (MEM_RF_en),
    .wb_rd    (WB_RD),
    .wb_en    (WB_RF_en),
    .sel      (sel_b)
  );

  hazard_forwarding_unit_fwd_select #(.REG_W(REG_W), .FWD_W(FWD_W)) u_fwd_c (
    .src      (ID_rd),
    .src_used (ID_is_store),
    .ex_rd    (EX_RD),
    .ex_en    (EX_RF_en),
    .mem_rd   (MEM_RD),
    .mem_en   (MEM_RF_en),
    .wb_rd    (WB_RD),
    .wb_en    (WB_RF_en),
    .sel      (sel_c)
  );

  // --------------------------------------------------------------------------
  // Load-use hazard detection
  // --------------------------------------------------------------------------
  logic ex_load_live;
  logic hz;

  assign ex_load_live = EX_load && EX_RF_en && (EX_RD != REG_W'(REG_G0));

  assign hz = ex_load_live &&
              ((ID_rs1 == EX_RD) ||
               (ID_uses_rs2 && (ID_rs2 == EX_RD)) ||
               (ID_is_store && (ID_rd == EX_RD)));

  // --------------------------------------------------------------------------
  // Stall FSM and annul-pending flag
  // --------------------------------------------------------------------------
  hz_state_e state;
  hz_state_e state_next;
  logic      annul_pending;
  logic      annul_pending_next;
  logic      stall_now;
  logic      clr_now;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block ordering.
  // The reset here is synchronous, matching the rest of this pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HZ_RUN;
      annul_pending <= 1'b0;
    end else begin
      state         <= state_next;
      annul_pending <= annul_pending_next;
    end
  end

  always_comb begin
    state_next         = state;
    annul_pending_next = 1'b0;
    stall_now          = 1'b0;
    clr_now            = 1'b0;

    if (!reset) begin
      unique case (state)
        HZ_RUN: begin
          if (hz) begin
            stall_now  = 1'b1;
            state_next = HZ_STALL;
          end
        end
        // The bubble is already in ID/EX; ignoring hz here bounds the stall
        // to exactly one cycle even if the load is still visible in EX.
        HZ_STALL: state_next = HZ_RUN;
        default:  state_next = HZ_RUN;
      endcase

      // An annul cannot clear IF/ID while it is held, so it waits. Requests
      // arriving while one is already pending merge into the same clear.
      if (stall_now) begin
        annul_pending_next = annul_pending || annul_req;
      end else begin
        clr_now = annul_pending || annul_req;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs; reset forces the idle, free-running pipeline view.
  // --------------------------------------------------------------------------
  assign fwd_a     = reset ? FWD_W'(FWD_RF) : sel_a;
  assign fwd_b     = reset ? FWD_W'(FWD_RF) : sel_b;
  assign fwd_c     = reset ? FWD_W'(FWD_RF) : sel_c;

  assign PC_LE     = !stall_now;
  assign nPC_LE    = !stall_now;
  assign IF_ID_LE  = !stall_now;
  assign ID_EX_clr = stall_now;
  assign stall     = stall_now;
  assign IF_ID_clr = clr_now;

`ifdef HAZARD_STATS_EN
  // --------------------------------------------------------------------------
  // Event counters; wrap naturally at 2^32.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      annul_count <= '0;
    end else begin
      if (stall_now) stall_count <= stall_count + 32'd1;
      if (clr_now)   annul_count <= annul_count + 32'd1;
    end
  end
`endif

endmodule : hazard_forwarding_unit

// File: doc/hazard_forwarding_unit.md
Name: hazard_forwarding_unit

Overview:
Control-side counterpart to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It reads the destination/enable fields those registers carry forward and sends back the load-enables, clears and operand-forwarding selects that govern them. It detects RAW hazards, inserts exactly one bubble on load-use, and annuls delay-slot instructions on request. It sits beside the ID stage in the SPARC pipeline.

Parameters:
REG_W, 5, register specifier width
FWD_W, 2, forwarding select width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
ID_rs1  in  REG_W  rs1 of instruction in ID
ID_rs2  in  REG_W  rs2 of instruction in ID
ID_rd  in  REG_W  rd in ID (source operand for stores)
ID_uses_rs2  in  1  0 when the instruction uses the i=1 immediate form
ID_is_store  in  1  rd is read as store data
EX_RD  in  REG_W  destination in EX
EX_RF_en  in  1  EX instruction writes the register file
EX_load  in  1  EX instruction is a load
MEM_RD  in  REG_W  destination in MEM
MEM_RF_en  in  1  MEM writes the register file
WB_RD  in  REG_W  destination in WB
WB_RF_en  in  1  WB writes the register file
annul_req  in  1  one-cycle pulse: annul the delay slot now in IF
fwd_a  out  FWD_W  operand A select (MX1)
fwd_b  out  FWD_W  operand B select (MX2)
fwd_c  out  FWD_W  store-data select (MX3)
PC_LE  out  1  PC load enable
nPC_LE  out  1  nPC load enable
IF_ID_LE  out  1  IF/ID load enable
IF_ID_clr  out  1  IF/ID clear (annul)
ID_EX_clr  out  1  ID/EX clear (bubble insertion)
stall  out  1  load-use stall active this cycle

Behaviour:
- Forward encoding: 00 register file, 01 EX, 10 MEM, 11 WB.
- Priority is EX > MEM > WB > register file. A source matches a stage when that stage's RF_en=1 and its RD equals the source.
- Register 0 (%g0) never matches, so its select is always 00.
- fwd_b is forced to 00 when ID_uses_rs2=0. fwd_c is forced to 00 when ID_is_store=0.
- Forwarding outputs are combinational from the current inputs and are valid in every state.
- Load-use hazard (hz) = EX_load & EX_RF_en & EX_RD≠0 & EX_RD matches any used source (rs1; rs2 if ID_uses_rs2; rd if ID_is_store).
- FSM state register, updated on posedge clk:
  - RUN: if hz, go to STALL; else stay in RUN.
  - STALL: unconditionally go to RUN. hz is ignored in STALL, which guarantees exactly one bubble.
- Stall outputs (combinational): when state=RUN and hz, drive PC_LE=nPC_LE=IF_ID_LE=0, ID_EX_clr=1, stall=1. Otherwise drive the LEs=1, ID_EX_clr=0, stall=0.
- The cycle after a stall, the load is in MEM and the consumer's forward select resolves to 10.
- Annul: annul_req in a cycle without a stall drives IF_ID_clr=1 in the same cycle.
- Annul during a stall: if annul_req coincides with a stall, set a pending flag. IF_ID_clr=1 is then driven in the first cycle the stall releases, and the flag clears.
- Multiple annul_req pulses while one is pending collapse into a single clear.
- Reset: state=RUN, pending=0. While reset=1, outputs are PC_LE=nPC_LE=IF_ID_LE=1, IF_ID_clr=0, ID_EX_clr=0, stall=0, all fwd=00.
- Reset asserted during a stall or with an annul pending abandons both; no clear is issued after reset deasserts.

Optional Feature:
HAZARD_STATS_EN
- When defined: adds outputs stall_count[31:0] and annul_count[31:0]. Each increments by 1 per stall cycle and per issued IF_ID_clr cycle respectively. Both wrap at 2^32 and are reset to 0.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the forward encodings FWD_RF, FWD_EX, FWD_MEM, FWD_WB;
  - state encodings HZ_RUN, HZ_STALL;
  - constant REG_G0=0.
- One sub-module, fwd_select: a combinational priority comparator, instantiated three times for operands a, b and c.

Test Plan:
- ID_rs1=5, EX_RD=5 EX_RF_en=1, MEM_RD=5 MEM_RF_en=1 -> fwd_a=01. With EX_RF_en=0 -> fwd_a=10. With MEM also off and WB_RD=5 WB_RF_en=1 -> fwd_a=11.
- ID_rs1=0, EX_RD=0 EX_RF_en=1 -> fwd_a=00, stall=0.
- EX_load=1 EX_RD=7, ID_rs2=7 ID_uses_rs2=1 -> cycle 0: stall=1, PC_LE=IF_ID_LE=0, ID_EX_clr=1. Cycle 1 (MEM_RD=7 MEM_RF_en=1, EX bubble): stall=0, fwd_b=10.
- Same load with ID_uses_rs2=0 and rs1≠7 -> no stall, fwd_b=00.
- annul_req pulsed during a stall cycle -> IF_ID_clr=0 that cycle and IF_ID_clr=1 on the next cycle. A second annul_req in that same cycle -> only a single clear cycle.
- Reset asserted in STALL with annul pending -> after deassert, state RUN, IF_ID_clr=0, all LEs=1. With HAZARD_STATS_EN, counters read 0.
